// File: rtl/clock_pkg.sv
// Shared types, constants and load-validation helpers for the hh:mm time-of-day counter.
package clock_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t hh_t;
    bcd_t hh_u;
    bcd_t mm_t;
    bcd_t mm_u;
  } hh_mm_t;

  localparam bcd_t       MAX_UNITS         = 4'd9;
  localparam bcd_t       MAX_MIN_TENS      = 4'd5;
  localparam logic [7:0] HOUR_MAX_24       = 8'h23;
  localparam logic [7:0] HOUR_MAX_12       = 8'h12;
  localparam logic [7:0] HOUR_MIN_12       = 8'h01;
  localparam logic [7:0] HOUR_PM_TOGGLE_12 = 8'h11;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  function automatic logic mm_valid(input logic [7:0] mm_v);
    return (mm_v[7:4] <= MAX_MIN_TENS) && (mm_v[3:0] <= MAX_UNITS);
  endfunction

  // Units digit is checked separately so values like 8'h1A are rejected.
  function automatic logic hh_valid(input logic [7:0] hh_v, input logic twelve);
    logic ok;
    ok = (hh_v[3:0] <= MAX_UNITS);
    if (twelve) ok = ok && (hh_v >= HOUR_MIN_12) && (hh_v <= HOUR_MAX_12);
    else        ok = ok && (hh_v <= HOUR_MAX_24);
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit: counts 0..wrap_val on enable, synchronous load, combinational carry out.
module bcd_digit_counter
  import clock_pkg::*;
#(
  parameter bcd_t RESET_VAL = 4'd0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  bcd_t wrap_val,
  input  logic ld,
  input  bcd_t ld_val,
  output bcd_t q,
  output logic carry_c
);

  bcd_t q_q;
  bcd_t q_d;

  always_comb begin
    q_d = q_q;
    if (ld)      q_d = ld_val;
    else if (en) q_d = (q_q == wrap_val) ? 4'd0 : q_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= RESET_VAL;
    else       q_q <= q_d;
  end

  assign q       = q_q;
  assign carry_c = en && (q_q == wrap_val);

endmodule

// File: rtl/hhmm_time_counter.sv
// Time-of-day counter: synchronises the minute clock, counts BCD hh:mm (24 h or 12 h),
// and accepts validated loads through a valid/ready handshake.
module hhmm_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          TWELVE_HOUR = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       min_clk,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic       set_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic       pm,
  output logic       min_pulse,
  output logic       hour_pulse,
  output logic       day_pulse,
  output logic       set_err
);

  localparam bcd_t       HH_T_RST     = TWELVE_HOUR ? HOUR_MAX_12[7:4] : 4'd0;
  localparam bcd_t       HH_U_RST     = TWELVE_HOUR ? HOUR_MAX_12[3:0] : 4'd0;
  localparam bcd_t       HH_WRAP_T    = TWELVE_HOUR ? HOUR_MIN_12[7:4] : 4'd0;
  localparam bcd_t       HH_WRAP_U    = TWELVE_HOUR ? HOUR_MIN_12[3:0] : 4'd0;
  localparam bcd_t       HH_TENS_WRAP = TWELVE_HOUR ? HOUR_MAX_12[7:4] : HOUR_MAX_24[7:4];
  localparam logic [7:0] HH_LAST      = TWELVE_HOUR ? HOUR_MAX_12 : HOUR_MAX_24;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   prev_q, prev_d;
  logic                   armed_q, armed_d;
  logic                   sync_last_c, tick_c;

  state_t state_q, state_d;
  logic   set_ready_q, set_ready_d;
  hh_mm_t ld_val_q, ld_val_d;
  logic   ld_pm_q, ld_pm_d;
  logic   ld_ok_q, ld_ok_d;
  logic   set_err_q, set_err_d;
  logic   accept_c, load_c, inc_c, set_ok_c;

  logic pm_q, pm_d;
  logic min_pulse_q, min_pulse_d;
  logic hour_pulse_q, hour_pulse_d;
  logic day_pulse_q, day_pulse_d;

  bcd_t       mm_units, mm_tens, hh_units, hh_tens;
  bcd_t       hh_t_ld_val, hh_u_ld_val;
  logic       mu_carry_c, mt_carry_c, hu_carry_c, ht_carry_c;
  logic       hour_adv_c, hour_wrap_c, hh_ld_c;
  logic [7:0] hh_c;

  // Edge detect is armed only after a genuine low sample, so a high min_clk at release is ignored.
  always_comb begin
    sync_last_c = sync_q[SYNC_STAGES-1];
    sync_d      = {sync_q[SYNC_STAGES-2:0], min_clk};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    prev_d      = sync_last_c;
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_last_c);
    tick_c      = armed_q & sync_last_c & ~prev_q;
  end

  always_comb begin
    state_d     = state_q;
    ld_val_d    = ld_val_q;
    ld_pm_d     = ld_pm_q;
    ld_ok_d     = ld_ok_q;
    set_err_d   = 1'b0;
    set_ok_c    = mm_valid(set_mm) && hh_valid(set_hh, TWELVE_HOUR);
    accept_c    = (state_q == RUN) && set_ready_q && set_valid;
    load_c      = (state_q == LOAD) && ld_ok_q;
    case (state_q)
      RUN: begin
        if (accept_c) begin
          state_d   = LOAD;
          ld_val_d  = hh_mm_t'({set_hh, set_mm});
          ld_pm_d   = set_pm;
          ld_ok_d   = set_ok_c;
          set_err_d = ~set_ok_c;
        end
      end
      LOAD:    state_d = RUN;
      default: state_d = RUN;
    endcase
    set_ready_d = (state_d == RUN);
    // Ticks seen while a load is being accepted or written are dropped whole.
    inc_c = tick_c && (state_q == RUN) && !accept_c;
  end

  bcd_digit_counter #(.RESET_VAL(4'd0)) u_mm_units (
    .clk(clk), .reset(reset), .en(inc_c), .wrap_val(MAX_UNITS),
    .ld(load_c), .ld_val(ld_val_q.mm_u), .q(mm_units), .carry_c(mu_carry_c)
  );

  bcd_digit_counter #(.RESET_VAL(4'd0)) u_mm_tens (
    .clk(clk), .reset(reset), .en(mu_carry_c), .wrap_val(MAX_MIN_TENS),
    .ld(load_c), .ld_val(ld_val_q.mm_t), .q(mm_tens), .carry_c(mt_carry_c)
  );

  // Hour wrap (23->00 or 12->01) is an override load rather than a natural digit carry.
  always_comb begin
    hh_c        = {hh_tens, hh_units};
    hour_adv_c  = mt_carry_c;
    hour_wrap_c = hour_adv_c && (hh_c == HH_LAST);
    hh_ld_c     = load_c || hour_wrap_c;
    hh_t_ld_val = load_c ? ld_val_q.hh_t : HH_WRAP_T;
    hh_u_ld_val = load_c ? ld_val_q.hh_u : HH_WRAP_U;
  end

  bcd_digit_counter #(.RESET_VAL(HH_U_RST)) u_hh_units (
    .clk(clk), .reset(reset), .en(hour_adv_c && !hour_wrap_c), .wrap_val(MAX_UNITS),
    .ld(hh_ld_c), .ld_val(hh_u_ld_val), .q(hh_units), .carry_c(hu_carry_c)
  );

  bcd_digit_counter #(.RESET_VAL(HH_T_RST)) u_hh_tens (
    .clk(clk), .reset(reset), .en(hu_carry_c), .wrap_val(HH_TENS_WRAP),
    .ld(hh_ld_c), .ld_val(hh_t_ld_val), .q(hh_tens), .carry_c(ht_carry_c)
  );

  always_comb begin
    pm_d         = 1'b0;
    day_pulse_d  = hour_wrap_c;
    min_pulse_d  = inc_c;
    hour_pulse_d = hour_adv_c;
    if (TWELVE_HOUR) begin
      pm_d        = pm_q;
      day_pulse_d = 1'b0;
      if (load_c) begin
        pm_d = ld_pm_q;
      end else if (hour_adv_c && (hh_c == HOUR_PM_TOGGLE_12)) begin
        pm_d        = ~pm_q;
        day_pulse_d = pm_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      fill_q       <= '0;
      prev_q       <= 1'b0;
      armed_q      <= 1'b0;
      state_q      <= RUN;
      set_ready_q  <= 1'b0;
      ld_val_q     <= '0;
      ld_pm_q      <= 1'b0;
      ld_ok_q      <= 1'b0;
      set_err_q    <= 1'b0;
      pm_q         <= 1'b0;
      min_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
      day_pulse_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      fill_q       <= fill_d;
      prev_q       <= prev_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      set_ready_q  <= set_ready_d;
      ld_val_q     <= ld_val_d;
      ld_pm_q      <= ld_pm_d;
      ld_ok_q      <= ld_ok_d;
      set_err_q    <= set_err_d;
      pm_q         <= pm_d;
      min_pulse_q  <= min_pulse_d;
      hour_pulse_q <= hour_pulse_d;
      day_pulse_q  <= day_pulse_d;
    end
  end

  assign set_ready  = set_ready_q;
  assign set_err    = set_err_q;
  assign hh         = {hh_tens, hh_units};
  assign mm         = {mm_tens, mm_units};
  assign pm         = pm_q;
  assign min_pulse  = min_pulse_q;
  assign hour_pulse = hour_pulse_q;
  assign day_pulse  = day_pulse_q;

endmodule

// File: tb/tb_hhmm_time_counter.sv
// Scoreboard bench: a 24 h and a 12 h instance share stimulus; a minutes-since-midnight model predicts events.
module tb_hhmm_time_counter;

  localparam int S      = 2;
  localparam int K_TICK = 0;
  localparam int K_ERR  = 1;
  localparam int K_RDY  = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] hh;
    logic [7:0] mm;
    logic       pm;
    logic       hp;
    logic       dp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       min_clk;
  logic       set_valid;
  logic [7:0] set_hh, set_mm;
  logic       set_pm;

  logic       rdy_o [2];
  logic [7:0] hh_o  [2];
  logic [7:0] mm_o  [2];
  logic       pm_o  [2];
  logic       mp_o  [2];
  logic       hp_o  [2];
  logic       dp_o  [2];
  logic       se_o  [2];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   t_m      [2];
  exp_t sb0 [$];
  exp_t sb1 [$];
  bit   rdy_prev [2];
  int   low_len  [2];

  hhmm_time_counter #(.SYNC_STAGES(S), .TWELVE_HOUR(1'b0)) u_dut24 (
    .clk(clk), .reset(reset), .min_clk(min_clk), .set_valid(set_valid), .set_ready(rdy_o[0]),
    .set_hh(set_hh), .set_mm(set_mm), .set_pm(set_pm), .hh(hh_o[0]), .mm(mm_o[0]), .pm(pm_o[0]),
    .min_pulse(mp_o[0]), .hour_pulse(hp_o[0]), .day_pulse(dp_o[0]), .set_err(se_o[0])
  );

  hhmm_time_counter #(.SYNC_STAGES(S), .TWELVE_HOUR(1'b1)) u_dut12 (
    .clk(clk), .reset(reset), .min_clk(min_clk), .set_valid(set_valid), .set_ready(rdy_o[1]),
    .set_hh(set_hh), .set_mm(set_mm), .set_pm(set_pm), .hh(hh_o[1]), .mm(mm_o[1]), .pm(pm_o[1]),
    .min_pulse(mp_o[1]), .hour_pulse(hp_o[1]), .day_pulse(dp_o[1]), .set_err(se_o[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (time as minutes since midnight) ----------------
  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic void disp(input int mode, input int t, output logic [7:0] h,
                               output logic [7:0] m, output logic p);
    int hr;
    hr = t / 60;
    m  = bcd(t % 60);
    if (mode == 0) begin
      h = bcd(hr);
      p = 1'b0;
    end else begin
      h = bcd((hr % 12 == 0) ? 12 : hr % 12);
      p = (hr >= 12);
    end
  endfunction

  function automatic bit ld_valid(input int mode, input logic [7:0] h, input logic [7:0] m);
    int hv;
    if (h[3:0] > 4'd9 || m[3:0] > 4'd9 || m[7:4] > 4'd5) return 1'b0;
    hv = int'(h[7:4]) * 10 + int'(h[3:0]);
    if (mode == 0) return hv <= 23;
    return (hv >= 1) && (hv <= 12);
  endfunction

  task automatic push_exp(input int i, input exp_t e);
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic pop_exp(input int i, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: -1, cyc: 0, hh: 8'h0, mm: 8'h0, pm: 1'b0, hp: 1'b0, dp: 1'b0};
    if (i == 0 && sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
    if (i == 1 && sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
  endtask

  task automatic model_tick(input int exp_cyc);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.kind = K_TICK;
      e.cyc  = exp_cyc;
      e.hp   = (t_m[i] % 60 == 59);
      e.dp   = (t_m[i] == 1439);
      t_m[i] = (t_m[i] + 1) % 1440;
      disp(i, t_m[i], e.hh, e.mm, e.pm);
      push_exp(i, e);
    end
  endtask

  task automatic model_load(input logic [7:0] h, input logic [7:0] m, input logic p);
    exp_t e;
    int   hv;
    for (int i = 0; i < 2; i++) begin
      e.hp = 1'b0;
      e.dp = 1'b0;
      e.cyc = 1;
      if (ld_valid(i, h, m)) begin
        hv = int'(h[7:4]) * 10 + int'(h[3:0]);
        if (i == 1) hv = (hv % 12) + (p ? 12 : 0);
        t_m[i] = hv * 60 + int'(m[7:4]) * 10 + int'(m[3:0]);
      end else begin
        e.kind = K_ERR;
        disp(i, t_m[i], e.hh, e.mm, e.pm);
        push_exp(i, e);
      end
      e.kind = K_RDY;
      disp(i, t_m[i], e.hh, e.mm, e.pm);
      push_exp(i, e);
    end
  endtask

  task automatic model_reset();
    exp_t e;
    sb0.delete();
    sb1.delete();
    for (int i = 0; i < 2; i++) begin
      t_m[i] = 0;
      e.kind = K_RDY;
      e.cyc  = -1;
      e.hp   = 1'b0;
      e.dp   = 1'b0;
      disp(i, 0, e.hh, e.mm, e.pm);
      push_exp(i, e);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int i);
    exp_t e;
    bit   ok;
    logic [18:0] got, want;
    got = {hh_o[i], mm_o[i], pm_o[i], hp_o[i], dp_o[i]};
    checks++;
    if ((hp_o[i] || dp_o[i]) && !mp_o[i]) begin
      failures++;
      $display("FAIL dut%0d stray_pulse: hour_pulse=%b day_pulse=%b without min_pulse", i, hp_o[i], dp_o[i]);
    end
    if (mp_o[i]) begin
      pop_exp(i, e, ok);
      want = {e.hh, e.mm, e.pm, e.hp, e.dp};
      checks++;
      if (!ok || e.kind != K_TICK || got != want) begin
        failures++;
        $display("FAIL dut%0d tick: got hh=%h mm=%h pm=%b hp=%b dp=%b, want kind=%0d hh=%h mm=%h pm=%b hp=%b dp=%b",
                 i, hh_o[i], mm_o[i], pm_o[i], hp_o[i], dp_o[i], e.kind, e.hh, e.mm, e.pm, e.hp, e.dp);
      end else begin
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL dut%0d tick_latency: got cycle %0d, want cycle %0d", i, cyc, e.cyc);
        end
      end
    end
    if (se_o[i]) begin
      pop_exp(i, e, ok);
      checks++;
      if (!ok || e.kind != K_ERR || mp_o[i] || {hh_o[i], mm_o[i], pm_o[i]} != {e.hh, e.mm, e.pm}) begin
        failures++;
        $display("FAIL dut%0d set_err: got hh=%h mm=%h pm=%b mp=%b, want kind=%0d hh=%h mm=%h pm=%b mp=0",
                 i, hh_o[i], mm_o[i], pm_o[i], mp_o[i], e.kind, e.hh, e.mm, e.pm);
      end
    end
    if (rdy_o[i] && !rdy_prev[i]) begin
      pop_exp(i, e, ok);
      checks++;
      if (!ok || e.kind != K_RDY || {hh_o[i], mm_o[i], pm_o[i]} != {e.hh, e.mm, e.pm}) begin
        failures++;
        $display("FAIL dut%0d ready_rise: got hh=%h mm=%h pm=%b, want kind=%0d hh=%h mm=%h pm=%b",
                 i, hh_o[i], mm_o[i], pm_o[i], e.kind, e.hh, e.mm, e.pm);
      end else if (e.cyc >= 0) begin
        checks++;
        if (low_len[i] != 1) begin
          failures++;
          $display("FAIL dut%0d ready_low_len: got %0d cycles, want 1", i, low_len[i]);
        end
      end
    end
    low_len[i]  = rdy_o[i] ? 0 : low_len[i] + 1;
    rdy_prev[i] = rdy_o[i];
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        rdy_prev[i] = 1'b0;
        low_len[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) mon(i);
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_vals();
    logic [7:0] h, m;
    logic       p;
    for (int i = 0; i < 2; i++) begin
      disp(i, 0, h, m, p);
      checks++;
      if ({hh_o[i], mm_o[i], pm_o[i], rdy_o[i], mp_o[i], hp_o[i], dp_o[i], se_o[i]} != {h, m, p, 5'b0}) begin
        failures++;
        $display("FAIL dut%0d reset_vals: got hh=%h mm=%h pm=%b rdy=%b mp=%b hp=%b dp=%b err=%b, want hh=%h mm=%h pm=%b rest 0",
                 i, hh_o[i], mm_o[i], pm_o[i], rdy_o[i], mp_o[i], hp_o[i], dp_o[i], se_o[i], h, m, p);
      end
    end
  endtask

  task automatic tick(input int hi, input int lo);
    @(negedge clk);
    min_clk = 1'b1;
    model_tick(cyc + 1 + S);
    repeat (hi) @(negedge clk);
    min_clk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic p);
    bit acc;
    acc = 1'b0;
    @(negedge clk);
    set_hh    = h;
    set_mm    = m;
    set_pm    = p;
    set_valid = 1'b1;
    model_load(h, m, p);
    for (int k = 0; k < 16 && !acc; k++) begin
      if (rdy_o[0]) begin
        @(posedge clk);
        acc = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL load_accept: got no set_ready within 16 cycles, want acceptance");
    end
    @(negedge clk);
    set_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rh, rm;
    int         r;
    reset     = 1'b1;
    min_clk   = 1'b0;
    set_valid = 1'b0;
    set_hh    = 8'h00;
    set_mm    = 8'h00;
    set_pm    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    repeat (S + 3) @(negedge clk);

    repeat (3) tick(2, S + 1);

    load(8'h23, 8'h58, 1'b0);
    tick(1, S + 1);
    tick(3, S + 2);

    load(8'h24, 8'h10, 1'b0);
    load(8'h12, 8'h5A, 1'b0);

    load(8'h11, 8'h59, 1'b0);
    tick(2, S + 1);
    load(8'h11, 8'h59, 1'b1);
    tick(2, S + 1);
    load(8'h12, 8'h59, 1'b1);
    tick(2, S + 1);
    load(8'h09, 8'h59, 1'b0);
    tick(2, S + 1);

    // Edge lands in the accept cycle: load wins, the edge is lost.
    @(negedge clk);
    min_clk = 1'b1;
    repeat (S - 1) @(negedge clk);
    load(8'h10, 8'h15, 1'b0);
    @(negedge clk);
    min_clk = 1'b0;
    repeat (S + 1) @(negedge clk);
    tick(2, S + 1);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        tick($urandom_range(1, 4), S + $urandom_range(0, 2));
      end else begin
        r = $urandom_range(0, 3);
        if (r == 0) begin
          rh = 8'($urandom);
          rm = 8'($urandom);
        end else if (r == 1) begin
          rh = (($urandom_range(0, 1)) != 0) ? 8'h23 : 8'h11;
          rm = (($urandom_range(0, 1)) != 0) ? 8'h59 : 8'h58;
        end else begin
          rh = bcd($urandom_range(0, 23));
          rm = bcd($urandom_range(0, 59));
        end
        load(rh, rm, 1'($urandom_range(0, 1)));
      end
    end

    // Reset in the LOAD cycle with min_clk held high.
    tick(S + 3, 0);
    @(negedge clk);
    set_hh    = 8'h07;
    set_mm    = 8'h30;
    set_pm    = 1'b1;
    set_valid = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals();
    set_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    min_clk = 1'b0;
    repeat (S + 1) @(negedge clk);
    tick(2, S + 1);

    repeat (S + 6) @(negedge clk);
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending events, want 0/0", sb0.size(), sb1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
